// File: rtl/magic_sync_checker.sv
// magic_sync_checker: Avalon-MM burst read master for the write-sync magic ROM.
// One start issues a single 1-4 beat burst at address 0. Every beat returned must
// carry {MAGIC_NUMBER_HIGH, MAGIC_NUMBER_LOW} in [63:0] and zeros above. The
// result goes back to the DMA write-fence control path as a done pulse plus flags.
module magic_sync_checker #(
    parameter logic [31:0] MAGIC_NUMBER_LOW  = 32'h53796E63,
    parameter logic [31:0] MAGIC_NUMBER_HIGH = 32'h5772745F,
    parameter int unsigned DATA_WIDTH        = 512,
    parameter int unsigned TIMEOUT_CYCLES    = 1023
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [2:0]            burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  err_mismatch,
    output logic                  err_timeout,
    output logic                  err_len,
    output logic [2:0]            beats_received,
    output logic [1:0]            avm_address,
    output logic                  avm_read,
    output logic [2:0]            avm_burstcount,
    input  logic [DATA_WIDTH-1:0] avm_readdata,
    input  logic                  avm_waitrequest,
    input  logic                  avm_readdatavalid
);

    localparam int unsigned       StallW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [StallW-1:0] StallMax = StallW'(TIMEOUT_CYCLES);
    localparam logic [63:0]       Magic    = {MAGIC_NUMBER_HIGH, MAGIC_NUMBER_LOW};
    localparam logic [2:0]        MaxBurst = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StData,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        burst_q, burst_d;
    logic [2:0]        beats_q, beats_d;
    logic [StallW-1:0] stall_q, stall_d;
    logic              err_mm_q, err_mm_d;
    logic              err_to_q, err_to_d;
    logic              err_len_q, err_len_d;

    logic              active;
    logic              cmd_accept;
    logic              beat_take;
    logic              beat_bad;
    logic [StallW-1:0] stall_inc;
    logic              stall_hit;

    // A transaction is in flight only in CMD and DATA; those are the states that
    // count beats and run the stall timer.
    assign active     = (state_q == StCmd) || (state_q == StData);
    assign cmd_accept = (state_q == StCmd) && !avm_waitrequest;

    // Beats beyond the latched burst length are dropped, which also keeps the
    // beat counter from exceeding 4.
    assign beat_take  = active && avm_readdatavalid && (beats_q < burst_q);

    assign beat_bad   = (avm_readdata[63:0] != Magic) || (|avm_readdata[DATA_WIDTH-1:64]);

    // Saturating stall count; any bus progress restarts it.
    assign stall_inc  = (stall_q == StallMax) ? stall_q : stall_q + StallW'(1);
    assign stall_hit  = active && !cmd_accept && !avm_readdatavalid && (stall_inc == StallMax);

    // Next-state and datapath updates for the check sequence.
    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        beats_d   = beats_q;
        stall_d   = stall_q;
        err_mm_d  = err_mm_q;
        err_to_d  = err_to_q;
        err_len_d = err_len_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_mm_d  = 1'b0;
                    err_to_d  = 1'b0;
                    err_len_d = 1'b0;
                    beats_d   = 3'd0;
                    stall_d   = '0;
                    if (burst_len == 3'd0) begin
                        // Nothing to read: report straight away without touching the bus.
                        err_len_d = 1'b1;
                        state_d   = StDone;
                    end else begin
                        burst_d = (burst_len > MaxBurst) ? MaxBurst : burst_len;
                        state_d = StCmd;
                    end
                end
            end

            StCmd, StData: begin
                if (beat_take) begin
                    beats_d = beats_q + 3'd1;
                    if (beat_bad) begin
                        err_mm_d = 1'b1;
                    end
                end

                if (cmd_accept || avm_readdatavalid) begin
                    stall_d = '0;
                end else begin
                    stall_d = stall_inc;
                end

                if (stall_hit) begin
                    err_to_d = 1'b1;
                    state_d  = StDone;
                end else if (state_q == StCmd) begin
                    if (cmd_accept) begin
                        state_d = StData;
                    end
                end else if (beats_d == burst_q) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset clears every output.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            burst_q   <= 3'd0;
            beats_q   <= 3'd0;
            stall_q   <= '0;
            err_mm_q  <= 1'b0;
            err_to_q  <= 1'b0;
            err_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            beats_q   <= beats_d;
            stall_q   <= stall_d;
            err_mm_q  <= err_mm_d;
            err_to_q  <= err_to_d;
            err_len_q <= err_len_d;
        end
    end

    assign busy           = (state_q != StIdle);
    assign done           = (state_q == StDone);
    assign avm_read       = (state_q == StCmd);
    assign avm_address    = 2'b00;
    assign avm_burstcount = burst_q;
    assign beats_received = beats_q;
    assign err_mismatch   = err_mm_q;
    assign err_timeout    = err_to_q;
    assign err_len        = err_len_q;
    assign error          = err_mm_q | err_to_q | err_len_q;

    // done is a single-cycle pulse and the beat counter never passes a full burst.
    done_single_pulse: assert property (@(posedge clk) disable iff (!reset_n) done |=> !done);
    beats_bounded: assert property (@(posedge clk) disable iff (!reset_n) beats_q <= MaxBurst);

endmodule

// File: tb/tb_magic_sync_checker.sv
// Bench for magic_sync_checker: a scheduled Avalon slave drives each check, and a
// cycle-arithmetic model derives when done fires and which flags must be set.
module tb_magic_sync_checker;

    localparam int unsigned DW   = 512;
    localparam int          T    = 8;
    localparam logic [63:0] GOOD = 64'h5772745F_53796E63;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [2:0]    burst_len;
    logic          busy;
    logic          done;
    logic          error;
    logic          err_mismatch;
    logic          err_timeout;
    logic          err_len;
    logic [2:0]    beats_received;
    logic [1:0]    avm_address;
    logic          avm_read;
    logic [2:0]    avm_burstcount;
    logic [DW-1:0] avm_readdata;
    logic          avm_waitrequest;
    logic          avm_readdatavalid;

    always #5 clk = ~clk;

    magic_sync_checker #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .burst_len        (burst_len),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .err_mismatch     (err_mismatch),
        .err_timeout      (err_timeout),
        .err_len          (err_len),
        .beats_received   (beats_received),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_burstcount   (avm_burstcount),
        .avm_readdata     (avm_readdata),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid)
    );

    int total = 0;
    int bad   = 0;

    // Slave behaviour for one check: waitrequest cycles, idle gap before each beat,
    // number of beats delivered, and which beats carry a flipped bit.
    typedef struct packed {
        logic [2:0]      len;
        logic [7:0]      wt;
        logic [4:0][3:0] gap;
        logic [2:0]      deliver;
        logic [4:0]      cmask;
        logic [4:0][8:0] cbit;
    } scen_t;

    typedef struct packed {
        scen_t      s;
        logic [7:0] e_done;
        logic [2:0] e_beats;
        logic [7:0] e_reads;
        logic       e_mm;
        logic       e_to;
        logic       e_len;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int len, input int wt, input int dlv, input int gi,
                                input int gv, input int ci, input int cb, input int ed,
                                input int eb, input int er, input logic mm, input logic to,
                                input logic le);
        vec_t v;
        v = '0;
        v.s.len     = 3'(len);
        v.s.wt      = 8'(wt);
        v.s.deliver = 3'(dlv);
        if (gi >= 0) v.s.gap[gi] = 4'(gv);
        if (ci >= 0) begin
            v.s.cmask[ci] = 1'b1;
            v.s.cbit[ci]  = 9'(cb);
        end
        v.e_done  = 8'(ed);
        v.e_beats = 3'(eb);
        v.e_reads = 8'(er);
        v.e_mm    = mm;
        v.e_to    = to;
        v.e_len   = le;
        return v;
    endfunction

    // Reference: walk the burst as a timeline. Any quiet stretch of T cycles while
    // the read is outstanding aborts it; otherwise done follows the last needed beat.
    function automatic vec_t model(input scen_t s);
        vec_t v;
        int   n;
        int   t;
        v   = '0;
        v.s = s;
        if (s.len == 3'd0) begin
            v.e_done = 8'd1;
            v.e_len  = 1'b1;
            return v;
        end
        n = (s.len > 3'd4) ? 4 : int'(s.len);
        if (int'(s.wt) >= T) begin
            v.e_done  = 8'(T + 1);
            v.e_reads = 8'(T);
            v.e_to    = 1'b1;
            return v;
        end
        t         = 1 + int'(s.wt);
        v.e_reads = 8'(t);
        for (int i = 0; i < n; i++) begin
            if (i >= int'(s.deliver) || int'(s.gap[i]) >= T) begin
                v.e_done = 8'(t + T + 1);
                v.e_to   = 1'b1;
                return v;
            end
            t         = t + 1 + int'(s.gap[i]);
            v.e_beats = v.e_beats + 3'd1;
            if (s.cmask[i]) v.e_mm = 1'b1;
        end
        v.e_done = 8'(t + 1);
        return v;
    endfunction

    function automatic int outs_word();
        return int'({busy, done, error, err_mismatch, err_timeout, err_len, beats_received,
                     avm_address, avm_read, avm_burstcount});
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int   bc[5];
        int   n, a, prev, last;
        int   dc, dcnt, reads, viol, f_beats, h_beats;
        logic busy1, busy_lo, f_mm, f_to, f_len, f_err, h_err;

        n    = (v.s.len > 3'd4) ? 4 : int'(v.s.len);
        a    = 1 + int'(v.s.wt);
        prev = a;
        for (int i = 0; i < 5; i++) begin
            bc[i] = -1;
            if (i < int'(v.s.deliver)) begin
                prev  = prev + 1 + int'(v.s.gap[i]);
                bc[i] = prev;
            end
        end
        dc = -1; dcnt = 0; reads = 0; viol = 0; f_beats = -1; h_beats = -1;
        busy1 = 1'b0; busy_lo = 1'b1; f_mm = 1'b0; f_to = 1'b0; f_len = 1'b0;
        f_err = 1'b0; h_err = 1'b1;
        last = int'(v.e_done) + 2;

        @(posedge clk); #1;
        start             = 1'b1;
        burst_len         = v.s.len;
        avm_waitrequest   = 1'b1;
        avm_readdatavalid = 1'b0;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= last; cyc++) begin
            // Start pulses while busy must be ignored.
            start             = (cyc <= int'(v.e_done)) ? 1'($urandom_range(0, 1)) : 1'b0;
            avm_waitrequest   = (cyc <= int'(v.s.wt));
            avm_readdatavalid = 1'b0;
            avm_readdata      = {16{$urandom}};
            for (int i = 0; i < 5; i++) begin
                if (bc[i] == cyc) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = {{(DW - 64){1'b0}}, GOOD};
                    if (v.s.cmask[i]) avm_readdata[v.s.cbit[i]] = ~avm_readdata[v.s.cbit[i]];
                end
            end
            @(negedge clk);
            if (done) begin
                dcnt++;
                if (dc < 0) begin
                    dc      = cyc;
                    f_mm    = err_mismatch;
                    f_to    = err_timeout;
                    f_len   = err_len;
                    f_err   = error;
                    f_beats = int'(beats_received);
                end
            end
            if (avm_read) begin
                reads++;
                if (avm_address != 2'b00 || int'(avm_burstcount) != n) viol++;
            end
            if (cyc == 1) busy1 = busy;
            if (cyc == last - 1) busy_lo = busy;
            if (cyc == last) begin
                h_beats = int'(beats_received);
                h_err   = error;
            end
            @(posedge clk); #1;
        end
        start             = 1'b0;
        avm_waitrequest   = 1'b1;
        avm_readdatavalid = 1'b0;

        check($sformatf("%s.done_cycle", tag), dc, int'(v.e_done));
        check($sformatf("%s.done_pulses", tag), dcnt, 1);
        check($sformatf("%s.read_cycles", tag), reads, int'(v.e_reads));
        check($sformatf("%s.cmd_fields", tag), viol, 0);
        check($sformatf("%s.busy_first", tag), int'(busy1), 1);
        check($sformatf("%s.busy_after", tag), int'(busy_lo), 0);
        check($sformatf("%s.err_mismatch", tag), int'(f_mm), int'(v.e_mm));
        check($sformatf("%s.err_timeout", tag), int'(f_to), int'(v.e_to));
        check($sformatf("%s.err_len", tag), int'(f_len), int'(v.e_len));
        check($sformatf("%s.error", tag), int'(f_err), int'(v.e_mm | v.e_to | v.e_len));
        check($sformatf("%s.beats", tag), f_beats, int'(v.e_beats));
        check($sformatf("%s.beats_held", tag), h_beats, int'(v.e_beats));
        check($sformatf("%s.error_held", tag), int'(h_err), int'(v.e_mm | v.e_to | v.e_len));
    endtask

    initial begin
        scen_t s;
        int    n;

        reset_n           = 1'b0;
        start             = 1'b0;
        burst_len         = 3'd0;
        avm_readdata      = '0;
        avm_waitrequest   = 1'b1;
        avm_readdatavalid = 1'b0;

        vecs[0]  = mk(4, 0, 4, -1, 0, -1, 0, 6, 4, 1, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1, 3, 1, -1, 0, -1, 0, 6, 1, 4, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(4, 0, 4, -1, 0, 2, 64, 6, 4, 1, 1'b1, 1'b0, 1'b0);
        vecs[3]  = mk(0, 0, 0, -1, 0, -1, 0, 1, 0, 0, 1'b0, 1'b0, 1'b1);
        vecs[4]  = mk(7, 0, 4, -1, 0, -1, 0, 6, 4, 1, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(2, 0, 0, -1, 0, -1, 0, 10, 0, 1, 1'b0, 1'b1, 1'b0);
        vecs[6]  = mk(1, 20, 1, -1, 0, -1, 0, 9, 0, 8, 1'b0, 1'b1, 1'b0);
        vecs[7]  = mk(1, 7, 1, -1, 0, -1, 0, 10, 1, 8, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(2, 0, 2, 1, 7, -1, 0, 11, 2, 1, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(2, 0, 2, 1, 8, -1, 0, 11, 1, 1, 1'b0, 1'b1, 1'b0);
        vecs[10] = mk(3, 0, 2, -1, 0, -1, 0, 12, 2, 1, 1'b0, 1'b1, 1'b0);
        vecs[11] = mk(2, 0, 3, -1, 0, -1, 0, 4, 2, 1, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(1, 0, 1, -1, 0, 0, 5, 3, 1, 1, 1'b1, 1'b0, 1'b0);
        vecs[13] = mk(4, 2, 4, -1, 0, 3, 511, 8, 4, 3, 1'b1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outs_word(), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int k = 0; k < 14; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        for (int k = 0; k < 40; k++) begin
            s     = '0;
            s.len = 3'($urandom_range(0, 7));
            s.wt  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(6, 10))
                                                 : 8'($urandom_range(0, 2));
            for (int i = 0; i < 5; i++) begin
                s.gap[i]  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(6, 9))
                                                        : 4'($urandom_range(0, 2));
                s.cmask[i] = ($urandom_range(0, 5) == 0);
                s.cbit[i]  = 9'($urandom_range(0, 511));
            end
            n = (s.len > 3'd4) ? 4 : int'(s.len);
            s.deliver = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 5))
                                                    : 3'(n + int'($urandom_range(0, 1)));
            run_vec(model(s), $sformatf("rnd%0d", k));
        end

        // Reset lands on the edge that would take beat 2; later beats must be ignored.
        @(posedge clk); #1;
        start     = 1'b1;
        burst_len = 3'd4;
        @(posedge clk); #1;
        start           = 1'b0;
        avm_waitrequest = 1'b0;
        @(posedge clk); #1;
        avm_readdatavalid = 1'b1;
        avm_readdata      = {{(DW - 64){1'b0}}, GOOD};
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_mid.outputs", outs_word(), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b1;
        @(negedge clk);
        check("rst_mid.late_beats", int'({busy, done, beats_received}), 0);
        run_vec(vecs[0], "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
